// File: rtl/bsg_tag_serial_tx_if.sv
// Parallel tag packet handshake (ready-and) feeding bsg_tag_serial_tx.
// master drives the packet, slave (the transmitter) returns ready_o.
interface bsg_tag_serial_tx_if
  #(parameter int els_p = 1024
   ,parameter int max_payload_width_p = 16
   );

  localparam int lg_els_lp = $clog2(els_p);
  localparam int lg_pw_lp  = $clog2(max_payload_width_p + 1);

  logic                           v_i;
  logic                           ready_o;
  logic [lg_els_lp-1:0]           node_id_i;
  logic                           data_not_reset_i;
  logic [lg_pw_lp-1:0]            len_i;
  logic [max_payload_width_p-1:0] payload_i;

  modport master (output v_i, node_id_i, data_not_reset_i, len_i, payload_i, input ready_o);
  modport slave  (input v_i, node_id_i, data_not_reset_i, len_i, payload_i, output ready_o);

endinterface

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag serial transmitter: latches a tag packet and shifts it out LSB first, one bit per clock.
// Optional 2-entry input FIFO enabled by defining BSG_TAG_SERIAL_TX_FIFO_EN.
module bsg_tag_serial_tx
  #(parameter int els_p = 1024
   ,parameter int max_payload_width_p = 16
   ,parameter int gap_p = 2
   )
  (input  logic              clk_i
  ,input  logic              reset_i
  ,bsg_tag_serial_tx_if.slave pkt
  ,output logic              tag_data_o
  ,output logic              tag_en_o
  ,output logic              busy_o
  );

  localparam int lg_els_lp  = $clog2(els_p);
  localparam int lg_pw_lp   = $clog2(max_payload_width_p + 1);
  localparam int m1_lp      = (lg_els_lp > lg_pw_lp) ? lg_els_lp : lg_pw_lp;
  localparam int m2_lp      = (m1_lp > max_payload_width_p) ? m1_lp : max_payload_width_p;
  localparam int max_cnt_lp = (m2_lp > gap_p) ? m2_lp : gap_p;
  localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_LEN, S_DNR, S_ID, S_PAY, S_GAP
  } state_e;

  typedef struct packed {
    logic [lg_els_lp-1:0]           node_id;
    logic                           dnr;
    logic [lg_pw_lp-1:0]            len;
    logic [max_payload_width_p-1:0] payload;
  } pkt_s;

  state_e                         state_reg, state_next;
  logic [cnt_w_lp-1:0]            cnt_reg, cnt_next;
  logic [lg_pw_lp-1:0]            len_reg, len_next;
  logic [lg_pw_lp-1:0]            len_sh_reg, len_sh_next;
  logic                           dnr_reg, dnr_next;
  logic [lg_els_lp-1:0]           id_sh_reg, id_sh_next;
  logic [max_payload_width_p-1:0] pay_sh_reg, pay_sh_next;
  logic                           tag_data_reg, tag_data_next;
  logic                           tag_en_reg, tag_en_next;
  logic                           busy_reg, busy_next;

  logic                           take;
  pkt_s                           in_pkt;
  pkt_s                           wr_pkt;
  logic [lg_pw_lp-1:0]            len_clamped;

  assign wr_pkt = {pkt.node_id_i, pkt.data_not_reset_i, pkt.len_i, pkt.payload_i};

`ifdef BSG_TAG_SERIAL_TX_FIFO_EN
  logic [1:0] fifo_cnt_reg;
  logic       wr_ptr_reg, rd_ptr_reg;
  logic       push;
  pkt_s       fifo_mem [2];

  assign pkt.ready_o = (fifo_cnt_reg != 2'd2);
  assign push        = pkt.v_i & pkt.ready_o;
  assign take        = (fifo_cnt_reg != 2'd0) & (state_reg == S_IDLE);
  assign in_pkt      = fifo_mem[rd_ptr_reg];

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    pkt_s entry_reg;
    always_ff @(posedge clk_i) begin
      if (push && (wr_ptr_reg == 1'(gi)))
        entry_reg <= wr_pkt;
    end
    assign fifo_mem[gi] = entry_reg;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fifo_cnt_reg <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (take) rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + 2'(push) - 2'(take);
    end
  end
`else
  logic ready_reg, ready_next;

  assign pkt.ready_o = ready_reg;
  assign take        = pkt.v_i & ready_reg;
  assign in_pkt      = wr_pkt;
`endif

  // Oversized lengths are clamped once, when the packet is latched.
  assign len_clamped = (in_pkt.len > lg_pw_lp'(max_payload_width_p))
                     ? lg_pw_lp'(max_payload_width_p) : in_pkt.len;

  // State register; reset lands in GAP so the idle guard also follows reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg    <= S_GAP;
      cnt_reg      <= '0;
      tag_data_reg <= 1'b0;
      tag_en_reg   <= 1'b0;
      busy_reg     <= 1'b1;
`ifndef BSG_TAG_SERIAL_TX_FIFO_EN
      ready_reg    <= 1'b0;
`endif
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      tag_data_reg <= tag_data_next;
      tag_en_reg   <= tag_en_next;
      busy_reg     <= busy_next;
`ifndef BSG_TAG_SERIAL_TX_FIFO_EN
      ready_reg    <= ready_next;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    len_reg    <= len_next;
    len_sh_reg <= len_sh_next;
    dnr_reg    <= dnr_next;
    id_sh_reg  <= id_sh_next;
    pay_sh_reg <= pay_sh_next;
  end

  // Next state: one shared counter times every field and is cleared on each state change.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg + 1'b1;
    len_next    = len_reg;
    len_sh_next = len_sh_reg;
    dnr_next    = dnr_reg;
    id_sh_next  = id_sh_reg;
    pay_sh_next = pay_sh_reg;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (take) begin
          state_next  = S_START;
          len_next    = len_clamped;
          len_sh_next = len_clamped;
          dnr_next    = in_pkt.dnr;
          id_sh_next  = in_pkt.node_id;
          pay_sh_next = in_pkt.payload;
        end
      end
      S_START: begin
        state_next = S_LEN;
        cnt_next   = '0;
      end
      S_LEN: begin
        len_sh_next = len_sh_reg >> 1;
        if (cnt_reg == cnt_w_lp'(lg_pw_lp - 1)) begin
          state_next = S_DNR;
          cnt_next   = '0;
        end
      end
      S_DNR: begin
        state_next = S_ID;
        cnt_next   = '0;
      end
      S_ID: begin
        id_sh_next = id_sh_reg >> 1;
        if (cnt_reg == cnt_w_lp'(lg_els_lp - 1)) begin
          state_next = (len_reg == '0) ? S_GAP : S_PAY;
          cnt_next   = '0;
        end
      end
      S_PAY: begin
        pay_sh_next = pay_sh_reg >> 1;
        if (cnt_next == cnt_w_lp'(len_reg)) begin
          state_next = S_GAP;
          cnt_next   = '0;
        end
      end
      S_GAP: begin
        if (cnt_reg == cnt_w_lp'(gap_p - 1)) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_GAP;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins come straight from flops.
  always_comb begin
    tag_en_next   = 1'b0;
    tag_data_next = 1'b0;
    busy_next     = (state_next != S_IDLE);
`ifndef BSG_TAG_SERIAL_TX_FIFO_EN
    ready_next    = (state_next == S_IDLE);
`endif
    case (state_next)
      S_START: begin tag_en_next = 1'b1; tag_data_next = 1'b1;           end
      S_LEN:   begin tag_en_next = 1'b1; tag_data_next = len_sh_next[0]; end
      S_DNR:   begin tag_en_next = 1'b1; tag_data_next = dnr_next;       end
      S_ID:    begin tag_en_next = 1'b1; tag_data_next = id_sh_next[0];  end
      S_PAY:   begin tag_en_next = 1'b1; tag_data_next = pay_sh_next[0]; end
      default: begin tag_en_next = 1'b0; tag_data_next = 1'b0;           end
    endcase
  end

  assign tag_data_o = tag_data_reg;
  assign tag_en_o   = tag_en_reg;
  assign busy_o     = busy_reg;

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Bench for bsg_tag_serial_tx: vector table plus scoreboard of expected serial bits.
// All sampling and driving happens on the falling clock edge.
module tb_bsg_tag_serial_tx;

  localparam int gap_lp = 2;

  logic clk = 1'b0;
  logic reset;
  logic tag_data, tag_en, busy;

  always #5 clk = ~clk;

  bsg_tag_serial_tx_if #(.els_p(1024), .max_payload_width_p(16)) pkt_if ();

  bsg_tag_serial_tx #(.els_p(1024), .max_payload_width_p(16), .gap_p(gap_lp)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .pkt        (pkt_if),
    .tag_data_o (tag_data),
    .tag_en_o   (tag_en),
    .busy_o     (busy)
  );

  typedef struct {
    logic [9:0]  node;
    logic        dnr;
    logic [4:0]  len;
    logic [15:0] pay;
    int          frame_len;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   en_cnt = 0;
  bit   exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic scramble();
    pkt_if.node_id_i        = 10'($urandom);
    pkt_if.payload_i        = 16'($urandom);
    pkt_if.len_i            = 5'($urandom);
    pkt_if.data_not_reset_i = 1'($urandom);
  endtask

  // One cycle: check the serial output against the scoreboard, then perturb idle inputs.
  task automatic tick();
    bit b;
    @(negedge clk);
    cyc++;
    if (tag_en === 1'b1) begin
      en_cnt++;
      if (exp_q.size() == 0) chk("extra_bit", 1, 0);
      else begin
        b = exp_q.pop_front();
        chk("serial_bit", tag_data, b);
      end
    end else begin
      chk("idle_data_low", tag_data, 0);
    end
    if (pkt_if.v_i !== 1'b1) scramble();
  endtask

  task automatic push_frame(input logic [9:0] node, input logic dnr,
                            input logic [4:0] len, input logic [15:0] pay);
    int l;
    l = (len > 5'd16) ? 16 : int'(len);
    exp_q.push_back(1'b1);
    for (int i = 0; i < 5; i++)  exp_q.push_back(5'(l) >> i & 5'd1 ? 1'b1 : 1'b0);
    exp_q.push_back(dnr);
    for (int i = 0; i < 10; i++) exp_q.push_back(node[i]);
    for (int i = 0; i < l; i++)  exp_q.push_back(pay[i]);
  endtask

  task automatic send(input vec_t v, output int t);
    int n;
    pkt_if.v_i              = 1'b1;
    pkt_if.node_id_i        = v.node;
    pkt_if.data_not_reset_i = v.dnr;
    pkt_if.len_i            = v.len;
    pkt_if.payload_i        = v.pay;
    n = 0;
    while (pkt_if.ready_o !== 1'b1 && n < 100) begin tick(); n++; end
    if (n == 100) chk("ready_timeout", 0, 1);
    push_frame(v.node, v.dnr, v.len, v.pay);
    t = cyc;
    en_cnt = 0;
    tick();
    pkt_if.v_i = 1'b0;
    scramble();
  endtask

  task automatic run_vec(input vec_t v);
    int t, n;
    send(v, t);
    chk("busy_in_frame", busy, 1);
    chk("ready_low_in_frame", pkt_if.ready_o, 0);
    n = 0;
    while (pkt_if.ready_o !== 1'b1 && n < 200) begin tick(); n++; end
    chk("frame_len", en_cnt, v.frame_len);
    chk("ready_spacing", cyc - t, v.frame_len + gap_lp + 1);
    chk("bits_left", exp_q.size(), 0);
    chk("busy_idle", busy, 0);
  endtask

  task automatic reset_hold();
    reset = 1'b1;
    pkt_if.v_i = 1'b0;
    repeat (3) tick();
    chk("reset_en", tag_en, 0);
    chk("reset_busy", busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, frames, idle_run;
    bit prev_en;
    vec_t v;
    vecs[0] = '{node: 10'd5,    dnr: 1'b1, len: 5'd4,  pay: 16'h000A, frame_len: 21};
    vecs[1] = '{node: 10'd1023, dnr: 1'b0, len: 5'd0,  pay: 16'hBEEF, frame_len: 17};
    vecs[2] = '{node: 10'd300,  dnr: 1'b1, len: 5'd31, pay: 16'hFFFF, frame_len: 33};
    vecs[3] = '{node: 10'd3,    dnr: 1'b1, len: 5'd16, pay: 16'h1234, frame_len: 33};
    vecs[4] = '{node: 10'd512,  dnr: 1'b0, len: 5'd1,  pay: 16'h0001, frame_len: 18};
    vecs[5] = '{node: 10'd0,    dnr: 1'b1, len: 5'd7,  pay: 16'h0055, frame_len: 24};
    reset = 1'b1;
    pkt_if.v_i = 1'b0;
    scramble();

`ifdef BSG_TAG_SERIAL_TX_FIFO_EN
    reset_hold();
    reset = 1'b0;
    chk("fifo_ready_after_reset", pkt_if.ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      v = vecs[k + 3];
      if (k == 2) begin
        pkt_if.v_i = 1'b1;
        chk("fifo_full_ready_low", pkt_if.ready_o, 0);
      end
      send(v, t);
      if (k < 2) pkt_if.v_i = 1'b1;
    end
    frames = (tag_en === 1'b1) ? 1 : 0;
    prev_en = (tag_en === 1'b1);
    idle_run = 0;
    n = 0;
    while (!(frames == 3 && tag_en !== 1'b1 && exp_q.size() == 0) && n < 400) begin
      tick();
      n++;
      if (tag_en === 1'b1 && !prev_en) begin
        if (frames > 0) chk("fifo_gap", idle_run, gap_lp + 1);
        frames++;
        idle_run = 0;
      end
      if (tag_en !== 1'b1) idle_run++;
      prev_en = (tag_en === 1'b1);
    end
    chk("fifo_frames", frames, 3);
    chk("fifo_bits_left", exp_q.size(), 0);
`else
    // Reset release with v_i held: ready rises two cycles later.
    reset_hold();
    chk("reset_ready", pkt_if.ready_o, 0);
    pkt_if.v_i = 1'b1;
    reset = 1'b0;
    tick();
    chk("ready_after_reset_c1", pkt_if.ready_o, 0);
    tick();
    chk("ready_after_reset_c2", pkt_if.ready_o, 1);
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while bit 8 of a frame is on the wire.
    v = '{node: 10'd77, dnr: 1'b1, len: 5'd8, pay: 16'h5A3C, frame_len: 25};
    send(v, t);
    n = 0;
    while (en_cnt < 9 && n < 50) begin tick(); n++; end
    chk("midframe_reached", en_cnt, 9);
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("midframe_reset_en", tag_en, 0);
    chk("midframe_reset_busy", busy, 1);
    reset = 1'b0;
    tick();
    chk("midframe_ready_c1", pkt_if.ready_o, 0);
    tick();
    chk("midframe_ready_c2", pkt_if.ready_o, 1);
    run_vec(vecs[4]);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
